prod_accum: RTL and testbench

- Downstream consumer of the pipelined array multiplier.
- Takes one 2*bw-bit product per accepted transfer and sums a frame of LEN products into a wide accumulator.
- Presents each frame result on a valid/ready output register.
- Turns the multiplier into a dot-product / MAC datapath; the multiplier output plus a valid bit drives in_prod/in_valid directly.

---
 rtl/prod_accum.sv | 127 ++++++++++++
 tb/tb_prod_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Frame accumulator behind the pipelined multiplier: sums LEN products per frame and
// presents each result on a valid/ready register. Define PROD_ACCUM_SAT_EN to saturate.
module prod_accum #(
  parameter int unsigned bw    = 8,
  parameter int unsigned LEN   = 16,
  parameter int unsigned ACC_W = 2 * bw + 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [2*bw-1:0]  in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [7:0]       LastCnt = 8'(LEN - 1);
  localparam logic [ACC_W-1:0] AccMax  = '1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             oovf_q, oovf_d;
  logic             ovalid_q, ovalid_d;

  logic             accept;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic             frame_ovf;
  logic [ACC_W-1:0] acc_next;

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid & in_ready;

  // Masking with in_valid keeps an undriven bus from reaching the adder.
  assign prod_ext  = {{(ACC_W + 1 - 2 * bw){1'b0}}, in_prod & {(2 * bw){in_valid}}};
  assign sum_wide  = {1'b0, acc_q} + prod_ext;
  assign frame_ovf = ovf_q | sum_wide[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
  // Once any carry has occurred the frame is pinned at full scale.
  assign acc_next = frame_ovf ? AccMax : sum_wide[ACC_W-1:0];
`else
  assign acc_next = sum_wide[ACC_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    oovf_d   = oovf_q;
    ovalid_d = ovalid_q;

    if (clr) begin
      state_d  = StIdle;
      acc_d    = '0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
      oovf_d   = 1'b0;
      ovalid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            if (cnt_q == LastCnt) begin
              sum_d    = acc_next;
              oovf_d   = frame_ovf;
              ovalid_d = 1'b1;
              acc_d    = '0;
              ovf_d    = 1'b0;
              cnt_d    = '0;
              state_d  = StHold;
            end else begin
              acc_d   = acc_next;
              ovf_d   = frame_ovf;
              cnt_d   = cnt_q + 8'd1;
              state_d = StAccum;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            ovalid_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      oovf_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      oovf_q   <= oovf_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three instances (defaults, ACC_W=18, LEN=2) checked every cycle
// against an exact-arithmetic frame model, plus hand-computed frame results.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chk_en = 1'b0;

  logic        clr_a [3];
  logic        iv_a  [3];
  logic [15:0] ip_a  [3];
  logic        or_a  [3];
  logic        ir_a  [3];
  logic        ov_a  [3];
  logic        ovf_a [3];
  logic [7:0]  fc_a  [3];
  logic [19:0] os0;
  logic [17:0] os1;
  logic [19:0] os2;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: exact frame sum, reduced only when the frame completes.
  int     m_cnt  [3];
  longint m_sum  [3];
  bit     m_hold [3];
  longint m_osum [3];
  bit     m_oovf [3];

  always #5 clk = ~clk;

  prod_accum u_dut0 (
    .CLK(clk), .RESETn(rst_n), .clr(clr_a[0]), .in_valid(iv_a[0]), .in_prod(ip_a[0]),
    .in_ready(ir_a[0]), .out_valid(ov_a[0]), .out_ready(or_a[0]), .out_sum(os0),
    .out_ovf(ovf_a[0]), .frame_cnt(fc_a[0])
  );

  prod_accum #(.ACC_W(18)) u_dut1 (
    .CLK(clk), .RESETn(rst_n), .clr(clr_a[1]), .in_valid(iv_a[1]), .in_prod(ip_a[1]),
    .in_ready(ir_a[1]), .out_valid(ov_a[1]), .out_ready(or_a[1]), .out_sum(os1),
    .out_ovf(ovf_a[1]), .frame_cnt(fc_a[1])
  );

  prod_accum #(.LEN(2)) u_dut2 (
    .CLK(clk), .RESETn(rst_n), .clr(clr_a[2]), .in_valid(iv_a[2]), .in_prod(ip_a[2]),
    .in_ready(ir_a[2]), .out_valid(ov_a[2]), .out_ready(or_a[2]), .out_sum(os2),
    .out_ovf(ovf_a[2]), .frame_cnt(fc_a[2])
  );

  function automatic int len_of(input int i);
    return (i == 2) ? 2 : 16;
  endfunction

  function automatic int accw_of(input int i);
    return (i == 1) ? 18 : 20;
  endfunction

  function automatic longint get_os(input int i);
    case (i)
      0:       return longint'(os0);
      1:       return longint'(os1);
      default: return longint'(os2);
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_hold[i] = 0; m_osum[i] = 0; m_oovf[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clr_a[i]) begin
          m_cnt[i] = 0; m_sum[i] = 0; m_hold[i] = 0; m_oovf[i] = 0;
        end else if (m_hold[i]) begin
          if (or_a[i]) m_hold[i] = 0;
        end else if (iv_a[i]) begin
          m_sum[i] += longint'(ip_a[i]);
          m_cnt[i]++;
          if (m_cnt[i] == len_of(i)) begin
            longint lim;
            lim = longint'(1) << accw_of(i);
            if (m_sum[i] >= lim) begin
              m_oovf[i] = 1;
`ifdef PROD_ACCUM_SAT_EN
              m_osum[i] = lim - 1;
`else
              m_osum[i] = m_sum[i] % lim;
`endif
            end else begin
              m_oovf[i] = 0;
              m_osum[i] = m_sum[i];
            end
            m_hold[i] = 1; m_cnt[i] = 0; m_sum[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("in_ready[%0d]", i), longint'(ir_a[i]), longint'(!m_hold[i]));
        check($sformatf("out_valid[%0d]", i), longint'(ov_a[i]), longint'(m_hold[i]));
        check($sformatf("out_sum[%0d]", i), get_os(i), m_osum[i]);
        check($sformatf("out_ovf[%0d]", i), longint'(ovf_a[i]), longint'(m_oovf[i]));
        check($sformatf("frame_cnt[%0d]", i), longint'(fc_a[i]), longint'(m_cnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input bit v, input logic [15:0] p);
    iv_a[i] = v;
    ip_a[i] = v ? p : 16'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      clr_a[i] = 1'b0; iv_a[i] = 1'b0; ip_a[i] = '0; or_a[i] = 1'b1;
    end
    repeat (3) step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset out_valid", longint'(ov_a[0]), 0);
    check("reset out_sum", get_os(0), 0);
    check("reset in_ready", longint'(ir_a[0]), 1);

    // Reset in the middle of a frame.
    for (int k = 0; k < 5; k++) begin drv(0, 1, 16'd7); step(); end
    drv(0, 0, 16'd0);
    check("frame_cnt before reset", longint'(fc_a[0]), 5);
    #2 rst_n = 1'b0;
    #1 check("async reset frame_cnt", longint'(fc_a[0]), 0);
    step();
    rst_n = 1'b1;
    step();
    check("in_ready after reset", longint'(ir_a[0]), 1);
    check("out_valid after reset", longint'(ov_a[0]), 0);

    // Steady frame of 118*181.
    for (int k = 0; k < 16; k++) begin drv(0, 1, 16'd21358); step(); end
    drv(0, 0, 16'd0);
    check("steady out_valid", longint'(ov_a[0]), 1);
    check("steady out_sum", get_os(0), 341728);
    check("steady in_ready low", longint'(ir_a[0]), 0);
    step();
    check("steady out_valid one cycle", longint'(ov_a[0]), 0);

    // Gapped 1..16 then backpressure with stray in_valid pulses.
    or_a[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      drv(0, 1, 16'(k));
      step();
      if (k % 3 == 0) begin drv(0, 0, 16'd0); repeat (2) step(); end
    end
    check("gapped out_sum", get_os(0), 136);
    for (int k = 0; k < 10; k++) begin
      drv(0, 1, 16'd999);
      step();
      check("hold out_sum", get_os(0), 136);
      check("hold in_ready", longint'(ir_a[0]), 0);
    end
    drv(0, 0, 16'd0);
    or_a[0] = 1'b1;
    step();
    check("hold released", longint'(ov_a[0]), 0);
    check("hold pulses ignored", longint'(fc_a[0]), 0);

    // Abort with clr while a product is presented.
    for (int k = 0; k < 7; k++) begin drv(0, 1, 16'd100); step(); end
    clr_a[0] = 1'b1;
    drv(0, 1, 16'd100);
    step();
    clr_a[0] = 1'b0;
    check("clr frame_cnt", longint'(fc_a[0]), 0);
    for (int k = 0; k < 16; k++) begin drv(0, 1, 16'd2); step(); end
    drv(0, 0, 16'd0);
    check("after clr out_sum", get_os(0), 32);
    step();

    // Overflow with an 18-bit accumulator.
    for (int k = 0; k < 16; k++) begin drv(1, 1, 16'd65025); step(); end
    drv(1, 0, 16'd0);
`ifdef PROD_ACCUM_SAT_EN
    check("ovf out_sum sat", get_os(1), 262143);
`else
    check("ovf out_sum wrap", get_os(1), 253968);
`endif
    check("ovf flag", longint'(ovf_a[1]), 1);
    step();

    // LEN=2: two frames back to back around the dead cycle.
    drv(2, 1, 16'd65025); step();
    drv(2, 1, 16'd0);     step();
    check("len2 out_sum", get_os(2), 65025);
    check("len2 out_ovf", longint'(ovf_a[2]), 0);
    drv(2, 1, 16'd3);     step();
    drv(2, 1, 16'd3);     step();
    drv(2, 1, 16'd4);     step();
    drv(2, 0, 16'd0);
    check("len2 second out_sum", get_os(2), 7);
    check("len2 second out_valid", longint'(ov_a[2]), 1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
